keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end for the calculator datapath. It drives the columns of a 4x4 keypad and samples its rows through a synchronizer. It debounces both press and release, then presents a level `key_pressed` plus a stable `keypad_out` code. These are exactly the inputs the calculator top consumes on its rising-edge key detection. One key is accepted per press, and `keypad_out` holds its value until the next accepted press.

## Interface
- `SCAN_DIV`, default 1000: cycles each column is driven before its rows are sampled. Legal range is 4 or more.
- `DEBOUNCE_CYCLES`, default 20000: number of consecutive stable samples needed to accept a press or a release. Legal range is 1 or more.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `row`  in  4  keypad rows. Active-low with external pull-ups; asynchronous to `clk`.
- `col`  out  4  keypad column drive. One-hot active-low, registered.
- `key_pressed`  out  1  level signal. High while a debounced key is held.
- `keypad_out`  out  25  code of the last accepted key, zero-extended from 4 bits.

## Operation
- Key map, as row r / col c to code:
  - r0: 1, 2, 3, A(plus)
  - r1: 4, 5, 6, B(minus)
  - r2: 7, 8, 9, C(multiply)
  - r3: F(decimal), 0, E(clear), D(divide)
- `row` passes through a 2-flop synchronizer before any use. The name `rs` below refers to the synchronized value.
- Column index `ci` is 0..3 and `col = ~(4'b1 << ci)`. `ci` wraps from 3 to 0.
- States:
  - SCAN: drive column `ci` and count `cnt` from 0 to SCAN_DIV-1. When `cnt == SCAN_DIV-1`, sample `rs`:
    - All ones: advance `ci`, set `cnt` to 0, stay in SCAN.
    - Exactly one zero bit: latch that pattern into `prow`, set the debounce counter `db` to 0, go to DEBOUNCE.
    - Two or more zero bits: treat as ambiguous and advance `ci` as if nothing were pressed.
  - DEBOUNCE: `ci` is frozen.
    - If `rs == prow`, increment `db`.
    - On any cycle with `rs != prow`, go back to SCAN with `ci` advanced and `cnt` at 0.
    - When `db` reaches DEBOUNCE_CYCLES, load `keypad_out` from the key map entry for (`prow`, `ci`), set `key_pressed` to 1, and go to HELD.
  - HELD: `ci` is frozen and `key_pressed` stays 1.
    - The first cycle with `rs == 4'hF` sets `db` to 0 and goes to RELEASE.
    - Extra keys in the same column that pull additional rows low are ignored while any row stays low.
  - RELEASE:
    - Each cycle with `rs == 4'hF` increments `db`.
    - Any low row returns to HELD with `key_pressed` still 1.
    - When `db` reaches DEBOUNCE_CYCLES, clear `key_pressed`, advance `ci`, set `cnt` to 0, and go to SCAN.
- `keypad_out` changes only on the cycle `key_pressed` rises. It is constant while `key_pressed` is high and after release.
- Each physical press produces exactly one 0-to-1 transition on `key_pressed`. There is no auto-repeat.
- Keys in other columns pressed during HELD/RELEASE are not seen, because only one column is driven. Scanning order decides priority: the first column scanned wins.

## Timing
- Reset values (asynchronous, on reset low): state SCAN, `ci` 0, `col` 4'b1110, `key_pressed` 0, `keypad_out` 0, all counters 0, synchronizer flops 4'hF.
- Reset taken mid-press returns to SCAN immediately with `key_pressed` 0. A key still held after reset is accepted again through a full SCAN and DEBOUNCE.
- `keypad_out` and `key_pressed` update on the same clock edge, so the consumer sees a valid code in the first cycle `key_pressed` is high.
- Press latency is measured from `row` going low while its column is driven and sampled:
  - Synchronizer: 2 cycles.
  - Remaining scan window: up to SCAN_DIV cycles.
  - Debounce: DEBOUNCE_CYCLES cycles.
  - Output register: 1 cycle.
- Release latency from `row` going high: 2 + DEBOUNCE_CYCLES + 1 cycles.
- A full idle scan of the keypad takes 4 × SCAN_DIV cycles.
- `key_pressed` is low for at least one cycle between two accepted presses.

## Test plan
The bench uses SCAN_DIV=4 and DEBOUNCE_CYCLES=8. The keypad model drives `row[r]` low when key (r,c) is pressed and `col[c]` is 0.

- Reset check: hold `reset` low, then release it.
  - Required: `col`=1110, `key_pressed`=0, `keypad_out`=0.
  - Then `col` steps 1101, 1011, 0111, 1110, holding each value for 4 cycles.
- Single press: press (1,2) for 60 cycles, then release.
  - Required: one rising edge of `key_pressed` with `keypad_out`=6.
  - `col` is held at 1011 while the key is down.
  - `key_pressed` falls 11 cycles after release and scanning resumes at 0111.
- Bounce: on key (3,0), toggle the row every 3 cycles for 24 cycles, then hold it low for 40 cycles.
  - Required: exactly one `key_pressed` edge, with `keypad_out`=0xF.
- Glitch: press (0,0) for 6 cycles only.
  - Required: `key_pressed` stays 0 and `keypad_out` is unchanged.
- Ambiguous and priority cases:
  - Press (0,1) and (2,1) together. Required: no press is accepted.
  - Press (0,0) and (0,3) together, then release both. Required: `keypad_out`=1 with one edge.
- Sequence and mid-press reset:
  - Press 1, F, 5, A in turn, releasing between them. Required: four edges with codes 1, 0xF, 5, 0xA. `keypad_out` holds 0xA afterwards.
  - Pulse `reset` while 'A' is held. Required: `key_pressed` goes to 0 at once, then rises again with code 0xA.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: row sense, column drive and the debounced key result.
// master: the scanner (samples row, drives col and the key outputs).
// slave:  the keypad model / calculator consumer side.
interface keypad_scanner_if;
    logic [3:0]  row;          // active-low rows, pulled up externally, async to clk
    logic [3:0]  col;          // one-hot active-low column drive
    logic        key_pressed;  // high while a debounced key is held
    logic [24:0] keypad_out;   // last accepted key code, zero-extended

    modport master (
        input  row,
        output col,
        output key_pressed,
        output keypad_out
    );

    modport slave (
        output row,
        input  col,
        input  key_pressed,
        input  keypad_out
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press and release debounce, one code per press.
// Latency: press 2 sync + up to SCAN_DIV window + DEBOUNCE_CYCLES + 1; release 2 + DEBOUNCE_CYCLES + 1.
// No backpressure: key_pressed is a level, keypad_out holds until the next accepted press.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   kp     keypad_scanner_if.master (row in, col / key_pressed / keypad_out out)
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,   // cycles per column before sampling, >= 4
    parameter int DEBOUNCE_CYCLES = 20000   // stable samples to accept press/release, >= 1
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Row/column position to key code.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: F 0 E D
    function automatic logic [3:0] key_code(input logic [3:0] prow, input logic [1:0] c);
        logic [1:0] r;
        logic [3:0] code;
        case (prow)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hF;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Row synchronizer; rs_q is the only row value the FSM ever looks at.
    logic [3:0]       sync1_q;
    logic [3:0]       rs_q;

    state_t           state_q, state_d;
    logic [1:0]       ci_q, ci_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic [3:0]       prow_q, prow_d;
    logic             kp_q, kp_d;
    logic [3:0]       code_q, code_d;
    logic [3:0]       col_q, col_d;

    logic [3:0]       rs_low;
    logic             one_low;

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'hF;
            rs_q    <= 4'hF;
            state_q <= ST_SCAN;
            ci_q    <= 2'd0;
            cnt_q   <= '0;
            db_q    <= '0;
            prow_q  <= 4'hF;
            kp_q    <= 1'b0;
            code_q  <= 4'h0;
            col_q   <= 4'b1110;
        end else begin
            sync1_q <= kp.row;
            rs_q    <= sync1_q;
            state_q <= state_d;
            ci_q    <= ci_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            prow_q  <= prow_d;
            kp_q    <= kp_d;
            code_q  <= code_d;
            col_q   <= col_d;
        end
    end

    // Exactly one row low means a single unambiguous key in the driven column.
    assign rs_low  = ~rs_q;
    assign one_low = (rs_low != 4'd0) && ((rs_low & (rs_low - 4'd1)) == 4'd0);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ci_d    = ci_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        prow_d  = prow_q;
        kp_d    = kp_q;
        code_d  = code_q;

        case (state_q)
            ST_SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        prow_d  = rs_q;
                        db_d    = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        // Idle column or multi-row ambiguity: move on.
                        ci_d = ci_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DEBOUNCE: begin
                if (rs_q != prow_q) begin
                    state_d = ST_SCAN;
                    ci_d    = ci_q + 2'd1;
                    cnt_d   = '0;
                end else if (db_q == DB_LAST) begin
                    // Code and key_pressed are registered on the same edge so
                    // the consumer sees a valid code with the rising level.
                    db_d    = db_q + DB_ONE;
                    code_d  = key_code(prow_q, ci_q);
                    kp_d    = 1'b1;
                    state_d = ST_HELD;
                end else begin
                    db_d = db_q + DB_ONE;
                end
            end

            ST_HELD: begin
                // Extra low rows in this column are ignored; only all-high
                // starts a release.
                if (rs_q == 4'hF) begin
                    db_d    = '0;
                    state_d = ST_RELEASE;
                end
            end

            default: begin // ST_RELEASE
                if (rs_q != 4'hF) begin
                    state_d = ST_HELD;
                end else if (db_q == DB_LAST) begin
                    db_d    = '0;
                    kp_d    = 1'b0;
                    ci_d    = ci_q + 2'd1;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end else begin
                    db_d = db_q + DB_ONE;
                end
            end
        endcase
    end

    // Column drive tracks the next column index so col is a clean register.
    always_comb begin
        col_d          = ~(4'b0001 << ci_d);
        kp.col         = col_q;
        kp.key_pressed = kp_q;
        kp.keypad_out  = {21'd0, code_q};
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SD       = 4;
    localparam int DB       = 8;
    localparam int REL_LAT  = 2 + DB + 1;          // release: sync + debounce + register
    localparam int RISE_MIN = 2 + 1 + DB;          // pressed just before its sample point
    localparam int RISE_MAX = 2 + 4 * SD + DB + 1; // pressed just after its sample point

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] press_m = 16'd0;   // bit r*4+c set while key (r,c) is held
    logic [3:0]  rows_m;

    int checks = 0;
    int errors = 0;
    int exp_code = 0;               // model of the last accepted key code

    int key_map [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{15, 0, 14, 13}};

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // Keypad: a held key pulls its row low only while its column is driven.
    always_comb begin
        rows_m = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_m[r*4+c] && !kif.col[c]) rows_m[r] = 1'b0;
    end
    assign kif.row = rows_m;

    // Edge monitor: counts rising edges and any keypad_out change not on one.
    int          rise_cnt = 0;
    int          stray_chg = 0;
    logic        prev_kp = 1'b0;
    logic [24:0] prev_out = 25'd0;
    always @(negedge clk) begin
        prev_kp  <= kif.key_pressed;
        prev_out <= kif.keypad_out;
        if (reset === 1'b1) begin
            if (kif.key_pressed && !prev_kp) rise_cnt <= rise_cnt + 1;
            else if (kif.keypad_out !== prev_out) stray_chg <= stray_chg + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until key_pressed equals val; -1 if the budget runs out.
    task automatic wait_kp(input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (kif.key_pressed === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        reset   = 1'b0;
        press_m = 16'd0;
        tick(3);
        checks++;
        if (kif.col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", kif.col); end
        checks++;
        if (kif.key_pressed !== 1'b0) begin errors++; $display("FAIL reset_kp: got %b expected 0", kif.key_pressed); end
        checks++;
        if (kif.keypad_out !== 25'd0) begin errors++; $display("FAIL reset_out: got %0h expected 0", kif.keypad_out); end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / SD) % 4));
            checks++;
            if (kif.col !== exp_col) begin errors++; $display("FAIL scan_col[%0d]: got %b expected %b", i, kif.col, exp_col); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_press();
        int n, held, bad_col, base;
        base = rise_cnt;
        press_m[1*4+2] = 1'b1;
        wait_kp(1'b1, 60, n);
        checks++;
        if (n < RISE_MIN || n > RISE_MAX) begin errors++; $display("FAIL single_rise_lat: got %0d expected %0d..%0d", n, RISE_MIN, RISE_MAX); end
        exp_code = key_map[1][2];
        checks++;
        if (kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL single_code: got %0h expected %0h", kif.keypad_out, exp_code); end
        held    = (n < 0) ? 60 : n;
        bad_col = 0;
        for (int i = held; i < 60; i++) begin
            if (kif.col !== 4'b1011) bad_col++;
            tick(1);
        end
        checks++;
        if (bad_col != 0) begin errors++; $display("FAIL single_col_hold: got %0d bad cycles expected 0", bad_col); end
        press_m = 16'd0;
        wait_kp(1'b0, 30, n);
        checks++;
        if (n != REL_LAT) begin errors++; $display("FAIL single_rel_lat: got %0d expected %0d", n, REL_LAT); end
        checks++;
        if (kif.col !== 4'b0111) begin errors++; $display("FAIL single_resume_col: got %b expected 0111", kif.col); end
        checks++;
        if (kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL single_code_after: got %0h expected %0h", kif.keypad_out, exp_code); end
        tick(5);
        checks++;
        if (rise_cnt - base != 1) begin errors++; $display("FAIL single_edges: got %0d expected 1", rise_cnt - base); end
    endtask

    task automatic test_bounce();
        int n, base;
        base = rise_cnt;
        for (int i = 0; i < 8; i++) begin
            press_m[3*4+0] = (i % 2 == 0);
            tick(3);
        end
        press_m[3*4+0] = 1'b1;
        tick(40);
        exp_code = key_map[3][0];
        checks++;
        if (kif.key_pressed !== 1'b1) begin errors++; $display("FAIL bounce_kp: got %b expected 1", kif.key_pressed); end
        checks++;
        if (kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL bounce_code: got %0h expected %0h", kif.keypad_out, exp_code); end
        press_m = 16'd0;
        wait_kp(1'b0, 30, n);
        checks++;
        if (n != REL_LAT) begin errors++; $display("FAIL bounce_rel_lat: got %0d expected %0d", n, REL_LAT); end
        tick(4);
        checks++;
        if (rise_cnt - base != 1) begin errors++; $display("FAIL bounce_edges: got %0d expected 1", rise_cnt - base); end
    endtask

    task automatic test_glitch();
        int base;
        logic seen;
        base = rise_cnt;
        seen = 1'b0;
        press_m[0] = 1'b1;
        tick(6);
        press_m = 16'd0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (kif.key_pressed === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL glitch_kp: got %b expected 0", seen); end
        checks++;
        if (kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL glitch_code: got %0h expected %0h", kif.keypad_out, exp_code); end
        checks++;
        if (rise_cnt - base != 0) begin errors++; $display("FAIL glitch_edges: got %0d expected 0", rise_cnt - base); end
    endtask

    task automatic test_ambiguous();
        int base;
        logic seen;
        base = rise_cnt;
        seen = 1'b0;
        press_m[0*4+1] = 1'b1;
        press_m[2*4+1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (kif.key_pressed === 1'b1) seen = 1'b1;
        end
        press_m = 16'd0;
        tick(10);
        checks++;
        if (seen !== 1'b0 || rise_cnt - base != 0) begin errors++; $display("FAIL ambiguous_accept: got kp=%b edges=%0d expected 0/0", seen, rise_cnt - base); end
        checks++;
        if (kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL ambiguous_code: got %0h expected %0h", kif.keypad_out, exp_code); end
    endtask

    task automatic test_priority();
        int n, base;
        logic [3:0] prev_col;
        base = rise_cnt;
        prev_col = kif.col;
        // Press both keys just as column 0 becomes driven, so column 0 is scanned first.
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (kif.col === 4'b1110 && prev_col !== 4'b1110) break;
            prev_col = kif.col;
        end
        press_m[0*4+0] = 1'b1;
        press_m[0*4+3] = 1'b1;
        wait_kp(1'b1, 60, n);
        exp_code = key_map[0][0];
        checks++;
        if (n < 0 || kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL priority_code: got %0h lat %0d expected %0h", kif.keypad_out, n, exp_code); end
        tick(20);
        press_m = 16'd0;
        wait_kp(1'b0, 30, n);
        tick(6);
        checks++;
        if (rise_cnt - base != 1) begin errors++; $display("FAIL priority_edges: got %0d expected 1", rise_cnt - base); end
    endtask

    task automatic test_sequence();
        int rr [4] = '{0, 3, 1, 0};
        int cc [4] = '{0, 0, 1, 3};
        int n, base;
        base = rise_cnt;
        for (int k = 0; k < 4; k++) begin
            press_m[rr[k]*4+cc[k]] = 1'b1;
            wait_kp(1'b1, 60, n);
            exp_code = key_map[rr[k]][cc[k]];
            checks++;
            if (n < RISE_MIN || n > RISE_MAX) begin errors++; $display("FAIL seq_rise_lat[%0d]: got %0d expected %0d..%0d", k, n, RISE_MIN, RISE_MAX); end
            checks++;
            if (kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL seq_code[%0d]: got %0h expected %0h", k, kif.keypad_out, exp_code); end
            tick(20);
            press_m = 16'd0;
            wait_kp(1'b0, 30, n);
            checks++;
            if (n != REL_LAT) begin errors++; $display("FAIL seq_rel_lat[%0d]: got %0d expected %0d", k, n, REL_LAT); end
            tick(6);
        end
        checks++;
        if (rise_cnt - base != 4) begin errors++; $display("FAIL seq_edges: got %0d expected 4", rise_cnt - base); end
        checks++;
        if (kif.keypad_out !== 25'hA) begin errors++; $display("FAIL seq_hold_code: got %0h expected a", kif.keypad_out); end
    endtask

    task automatic test_reset_mid_press();
        int n;
        press_m[0*4+3] = 1'b1;
        wait_kp(1'b1, 60, n);
        exp_code = key_map[0][3];
        checks++;
        if (n < 0 || kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL midrst_first: got %0h lat %0d expected %0h", kif.keypad_out, n, exp_code); end
        tick(5);
        reset = 1'b0;
        #1;
        checks++;
        if (kif.key_pressed !== 1'b0) begin errors++; $display("FAIL midrst_kp_clear: got %b expected 0", kif.key_pressed); end
        checks++;
        if (kif.col !== 4'b1110 || kif.keypad_out !== 25'd0) begin errors++; $display("FAIL midrst_state: got col %b out %0h expected 1110/0", kif.col, kif.keypad_out); end
        tick(2);
        reset = 1'b1;
        wait_kp(1'b1, 60, n);
        checks++;
        if (n < RISE_MIN || n > RISE_MAX) begin errors++; $display("FAIL midrst_rise_lat: got %0d expected %0d..%0d", n, RISE_MIN, RISE_MAX); end
        checks++;
        if (kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL midrst_code: got %0h expected %0h", kif.keypad_out, exp_code); end
        tick(10);
        press_m = 16'd0;
        wait_kp(1'b0, 30, n);
        checks++;
        if (n != REL_LAT) begin errors++; $display("FAIL midrst_rel_lat: got %0d expected %0d", n, REL_LAT); end
        tick(6);
    endtask

    task automatic test_random();
        int r, c, hold, n, base;
        for (int k = 0; k < 12; k++) begin
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            hold = $urandom_range(35, 70);
            base = rise_cnt;
            press_m[r*4+c] = 1'b1;
            wait_kp(1'b1, 60, n);
            exp_code = key_map[r][c];
            checks++;
            if (n < RISE_MIN || n > RISE_MAX) begin errors++; $display("FAIL rnd_rise_lat[%0d]: got %0d expected %0d..%0d", k, n, RISE_MIN, RISE_MAX); end
            checks++;
            if (kif.keypad_out !== 25'(exp_code)) begin errors++; $display("FAIL rnd_code[%0d] key(%0d,%0d): got %0h expected %0h", k, r, c, kif.keypad_out, exp_code); end
            tick((n < 0) ? 0 : hold - n);
            press_m = 16'd0;
            wait_kp(1'b0, 30, n);
            checks++;
            if (n != REL_LAT) begin errors++; $display("FAIL rnd_rel_lat[%0d]: got %0d expected %0d", k, n, REL_LAT); end
            tick($urandom_range(2, 20));
            checks++;
            if (rise_cnt - base != 1) begin errors++; $display("FAIL rnd_edges[%0d]: got %0d expected 1", k, rise_cnt - base); end
        end
        checks++;
        if (stray_chg != 0) begin errors++; $display("FAIL stray_out_changes: got %0d expected 0", stray_chg); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_glitch();
        test_ambiguous();
        test_priority();
        test_sequence();
        test_reset_mid_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
